// File: rtl/gfx_vid_ram_arbiter.sv
// Video RAM arbiter: the LCD refresh reader has priority over the CPU and graphics-engine ports,
// which share the RAM round-robin. A starvation limiter bounds how long refresh can lock them out.
module gfx_vid_ram_arbiter #(
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              mclk,
  input  logic              puc_rst,
  input  logic              ref_req_i,
  input  logic              cpu_req_i,
  input  logic              gpu_req_i,
  input  logic              ref_we_i,
  input  logic              cpu_we_i,
  input  logic              gpu_we_i,
  input  logic [ADDR_W-1:0] ref_addr_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [ADDR_W-1:0] gpu_addr_i,
  input  logic [DATA_W-1:0] cpu_din_i,
  input  logic [DATA_W-1:0] gpu_din_i,
  output logic              ref_ack_o,
  output logic              cpu_ack_o,
  output logic              gpu_ack_o,
  output logic              ref_rdv_o,
  output logic              cpu_rdv_o,
  output logic              gpu_rdv_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              vid_ram_cen_o,
  output logic              vid_ram_wen_o,
  output logic [ADDR_W-1:0] vid_ram_addr_o,
  output logic [DATA_W-1:0] vid_ram_din_o,
  input  logic [DATA_W-1:0] vid_ram_dout_i
);

  localparam bit              LIMIT_EN = (STARVE_LIMIT > 32'sd0);
  localparam int              CNT_W    = LIMIT_EN ? $clog2(STARVE_LIMIT + 32'sd1) : 32'sd1;
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic              rr_last_gpu_r;
  logic [CNT_W-1:0]  starve_cnt_r;
  logic [2:0]        rd_pend_r;
  logic [ADDR_W-1:0] addr_hold_r;
  logic [DATA_W-1:0] din_hold_r;
  logic [DATA_W-1:0] rdata_hold_r;

  logic              cg_pend_s;
  logic              starve_hit_s;
  logic              ref_gnt_s;
  logic              cpu_gnt_s;
  logic              gpu_gnt_s;
  logic              any_gnt_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_din_s;

  // Grant selection: refresh first unless starved-out, then round-robin between cpu and gpu
  always_comb begin
    ref_gnt_s    = 1'b0;
    cpu_gnt_s    = 1'b0;
    gpu_gnt_s    = 1'b0;
    cg_pend_s    = cpu_req_i | gpu_req_i;
    starve_hit_s = LIMIT_EN && (starve_cnt_r == LIMIT_C) && cg_pend_s;
    if (puc_rst) begin
      ref_gnt_s = 1'b0;
    end else if (ref_req_i && !starve_hit_s) begin
      ref_gnt_s = 1'b1;
    end else if (cpu_req_i && gpu_req_i) begin
      if (rr_last_gpu_r) begin
        cpu_gnt_s = 1'b1;
      end else begin
        gpu_gnt_s = 1'b1;
      end
    end else if (cpu_req_i) begin
      cpu_gnt_s = 1'b1;
    end else if (gpu_req_i) begin
      gpu_gnt_s = 1'b1;
    end else begin
      cpu_gnt_s = 1'b0;
    end
    any_gnt_s = ref_gnt_s | cpu_gnt_s | gpu_gnt_s;
  end

  // Winner's access fields; address and data fall back to the last driven values when idle
  always_comb begin
    sel_we_s   = 1'b0;
    sel_addr_s = addr_hold_r;
    sel_din_s  = din_hold_r;
    if (ref_gnt_s) begin
      // refresh is read-only: its write-enable input is deliberately discarded
      sel_we_s   = ref_we_i & 1'b0;
      sel_addr_s = ref_addr_i;
    end else if (cpu_gnt_s) begin
      sel_we_s   = cpu_we_i;
      sel_addr_s = cpu_addr_i;
      sel_din_s  = cpu_din_i;
    end else if (gpu_gnt_s) begin
      sel_we_s   = gpu_we_i;
      sel_addr_s = gpu_addr_i;
      sel_din_s  = gpu_din_i;
    end else begin
      sel_we_s   = 1'b0;
    end
  end

  // Output drive; reset forces every output to its idle value immediately
  always_comb begin
    ref_ack_o      = ref_gnt_s;
    cpu_ack_o      = cpu_gnt_s;
    gpu_ack_o      = gpu_gnt_s;
    vid_ram_cen_o  = ~any_gnt_s;
    vid_ram_wen_o  = any_gnt_s ? ~sel_we_s : 1'b1;
    vid_ram_addr_o = puc_rst ? {ADDR_W{1'b0}} : sel_addr_s;
    vid_ram_din_o  = puc_rst ? {DATA_W{1'b0}} : sel_din_s;
    {ref_rdv_o, cpu_rdv_o, gpu_rdv_o} = rd_pend_r & {3{~puc_rst}};
    if (puc_rst) begin
      rdata_o = {DATA_W{1'b0}};
    end else if (|rd_pend_r) begin
      rdata_o = vid_ram_dout_i;
    end else begin
      rdata_o = rdata_hold_r;
    end
  end

  // Round-robin pointer: moves only on a cpu or gpu grant; resets to gpu so cpu wins the first tie
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      rr_last_gpu_r <= 1'b1;
    end else if (cpu_gnt_s || gpu_gnt_s) begin
      rr_last_gpu_r <= gpu_gnt_s;
    end else begin
      rr_last_gpu_r <= rr_last_gpu_r;
    end
  end

  // Starvation counter: counts refresh grants that blocked a pending cpu/gpu request
  always_ff @(posedge mclk) begin
    if (puc_rst || !LIMIT_EN) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (cpu_gnt_s || gpu_gnt_s || !cg_pend_s) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (ref_gnt_s) begin
      starve_cnt_r <= starve_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Read-return tracking and held RAM/read-data values
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      rd_pend_r    <= 3'b000;
      addr_hold_r  <= {ADDR_W{1'b0}};
      din_hold_r   <= {DATA_W{1'b0}};
      rdata_hold_r <= {DATA_W{1'b0}};
    end else begin
      rd_pend_r   <= {ref_gnt_s, cpu_gnt_s & ~cpu_we_i, gpu_gnt_s & ~gpu_we_i};
      addr_hold_r <= sel_addr_s;
      din_hold_r  <= sel_din_s;
      if (|rd_pend_r) begin
        rdata_hold_r <= vid_ram_dout_i;
      end else begin
        rdata_hold_r <= rdata_hold_r;
      end
    end
  end

endmodule

// File: tb/tb_gfx_vid_ram_arbiter.sv
// Directed bench for gfx_vid_ram_arbiter with a synchronous RAM model and a second
// instance built with the starvation limit disabled.
module tb_gfx_vid_ram_arbiter;

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic        ref_req, cpu_req, gpu_req;
  logic        ref_we, cpu_we, gpu_we;
  logic [16:0] ref_addr, cpu_addr, gpu_addr;
  logic [15:0] cpu_din, gpu_din;
  logic        ref_ack, cpu_ack, gpu_ack, ref_rdv, cpu_rdv, gpu_rdv;
  logic [15:0] rdata;
  logic        cen, wen;
  logic [16:0] ram_addr;
  logic [15:0] ram_din, ram_dout;
  logic        z_ref_ack, z_cpu_ack, z_gpu_ack, z_ref_rdv, z_cpu_rdv, z_gpu_rdv;
  logic [15:0] z_rdata, z_din;
  logic        z_cen, z_wen;
  logic [16:0] z_addr;

  logic [15:0] mem [0:31];
  logic        load_mem;
  logic [2:0]  prev_rd = 3'b000;
  int          errors  = 0;
  int          checks  = 0;

  always #5 mclk = ~mclk;

  gfx_vid_ram_arbiter #(.ADDR_W(17), .DATA_W(16), .STARVE_LIMIT(8)) dut (
    .mclk(mclk), .puc_rst(puc_rst),
    .ref_req_i(ref_req), .cpu_req_i(cpu_req), .gpu_req_i(gpu_req),
    .ref_we_i(ref_we), .cpu_we_i(cpu_we), .gpu_we_i(gpu_we),
    .ref_addr_i(ref_addr), .cpu_addr_i(cpu_addr), .gpu_addr_i(gpu_addr),
    .cpu_din_i(cpu_din), .gpu_din_i(gpu_din),
    .ref_ack_o(ref_ack), .cpu_ack_o(cpu_ack), .gpu_ack_o(gpu_ack),
    .ref_rdv_o(ref_rdv), .cpu_rdv_o(cpu_rdv), .gpu_rdv_o(gpu_rdv),
    .rdata_o(rdata), .vid_ram_cen_o(cen), .vid_ram_wen_o(wen),
    .vid_ram_addr_o(ram_addr), .vid_ram_din_o(ram_din), .vid_ram_dout_i(ram_dout)
  );

  gfx_vid_ram_arbiter #(.ADDR_W(17), .DATA_W(16), .STARVE_LIMIT(0)) dut0 (
    .mclk(mclk), .puc_rst(puc_rst),
    .ref_req_i(ref_req), .cpu_req_i(cpu_req), .gpu_req_i(gpu_req),
    .ref_we_i(ref_we), .cpu_we_i(cpu_we), .gpu_we_i(gpu_we),
    .ref_addr_i(ref_addr), .cpu_addr_i(cpu_addr), .gpu_addr_i(gpu_addr),
    .cpu_din_i(cpu_din), .gpu_din_i(gpu_din),
    .ref_ack_o(z_ref_ack), .cpu_ack_o(z_cpu_ack), .gpu_ack_o(z_gpu_ack),
    .ref_rdv_o(z_ref_rdv), .cpu_rdv_o(z_cpu_rdv), .gpu_rdv_o(z_gpu_rdv),
    .rdata_o(z_rdata), .vid_ram_cen_o(z_cen), .vid_ram_wen_o(z_wen),
    .vid_ram_addr_o(z_addr), .vid_ram_din_o(z_din), .vid_ram_dout_i(ram_dout)
  );

  // Synchronous RAM: read data appears the cycle after the read
  always @(posedge mclk) begin
    if (load_mem) begin
      mem[5]  <= 16'h5A5A;
      mem[7]  <= 16'h0707;
      mem[18] <= 16'hBEEF;
    end else if (!cen) begin
      if (!wen) mem[ram_addr[4:0]] <= ram_din;
      else      ram_dout <= mem[ram_addr[4:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic idle();
    ref_req = 1'b0; cpu_req = 1'b0; gpu_req = 1'b0;
    ref_we  = 1'b0; cpu_we  = 1'b0; gpu_we  = 1'b0;
  endtask

  // Continuous protocol checks: one grant at most, grant only when requested, rdv one cycle after each read
  always @(negedge mclk) begin
    chk("ack_onehot0", 32'($onehot0({ref_ack, cpu_ack, gpu_ack})), 32'd1);
    chk("ack_needs_req", 32'({ref_ack, cpu_ack, gpu_ack} & ~{ref_req, cpu_req, gpu_req}), 32'd0);
    chk("rdv_follows_read", 32'({ref_rdv, cpu_rdv, gpu_rdv}), 32'(prev_rd & {3{~puc_rst}}));
    prev_rd = {ref_ack, cpu_ack & ~cpu_we, gpu_ack & ~gpu_we};
  end

  initial begin
    idle();
    puc_rst  = 1'b1;
    load_mem = 1'b1;
    ref_addr = 17'h0; cpu_addr = 17'h0; gpu_addr = 17'h0;
    cpu_din  = 16'h0; gpu_din  = 16'h0;
    cpu_req  = 1'b1;
    tick(); tick();
    load_mem = 1'b0;
    #2;
    chk("rst_acks", 32'({ref_ack, cpu_ack, gpu_ack}), 32'd0);
    chk("rst_rdv", 32'({ref_rdv, cpu_rdv, gpu_rdv}), 32'd0);
    chk("rst_cen_wen", 32'({cen, wen}), 32'd3);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_din", 32'(ram_din), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);

    // Single cpu read, issued in the first cycle out of reset
    tick();
    puc_rst = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00012;
    #2;
    chk("rd_ack", 32'({ref_ack, cpu_ack, gpu_ack}), 32'd2);
    chk("rd_cen_wen", 32'({cen, wen}), 32'd1);
    chk("rd_addr", 32'(ram_addr), 32'h12);
    tick(); idle(); #2;
    chk("rd_rdv", 32'({ref_rdv, cpu_rdv, gpu_rdv}), 32'd2);
    chk("rd_rdata", 32'(rdata), 32'hBEEF);
    chk("idle_cen_wen", 32'({cen, wen}), 32'd3);
    chk("idle_addr_hold", 32'(ram_addr), 32'h12);

    // Round-robin writes from reset
    tick(); puc_rst = 1'b1;
    tick(); puc_rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h1; cpu_din = 16'h1111;
    gpu_req = 1'b1; gpu_we = 1'b1; gpu_addr = 17'h2; gpu_din = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      #2;
      chk("rr_ack", 32'({ref_ack, cpu_ack, gpu_ack}), (i % 2 == 0) ? 32'd2 : 32'd1);
      chk("rr_wen", 32'({cen, wen}), 32'd0);
      chk("rr_din", 32'(ram_din), (i % 2 == 0) ? 32'h1111 : 32'h2222);
      chk("rr_no_rdv", 32'({ref_rdv, cpu_rdv, gpu_rdv}), 32'd0);
    end

    // Starvation limiter: refresh held against a pending cpu read
    tick(); idle();
    tick();
    ref_req = 1'b1; ref_we = 1'b1; ref_addr = 17'h5;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h12;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      #2;
      chk("starve_ack", 32'({ref_ack, cpu_ack, gpu_ack}), (i == 8) ? 32'd2 : 32'd4);
      if (i == 0) chk("ref_wen_ignored", 32'({cen, wen}), 32'd1);
      if (i == 1) chk("ref_rdata", 32'(rdata), 32'h5A5A);
      if (i == 9) chk("starve_cpu_rdata", 32'(rdata), 32'hBEEF);
    end

    // Limit disabled: refresh never yields to gpu
    tick(); idle();
    ref_req = 1'b1; ref_addr = 17'h5; gpu_req = 1'b1; gpu_addr = 17'h7;
    for (int i = 0; i < 100; i++) begin
      if (i > 0) tick();
      #2;
      chk("nolimit_ack", 32'({z_ref_ack, z_gpu_ack}), 32'd2);
    end

    // Reset arriving right after a gpu read grant discards the return
    tick(); idle();
    tick();
    gpu_req = 1'b1; gpu_we = 1'b0; gpu_addr = 17'h7;
    #2;
    chk("mid_gpu_ack", 32'({ref_ack, cpu_ack, gpu_ack}), 32'd1);
    tick(); idle(); puc_rst = 1'b1; #2;
    chk("mid_rst_rdv", 32'(gpu_rdv), 32'd0);
    chk("mid_rst_rdata", 32'(rdata), 32'd0);
    chk("mid_rst_cen", 32'(cen), 32'd1);

    // Cancelled request: cpu asks while refresh wins, then withdraws
    tick(); puc_rst = 1'b0;
    ref_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
    #2;
    chk("cancel_ref_wins", 32'({ref_ack, cpu_ack, gpu_ack}), 32'd4);
    tick(); idle(); #2;
    chk("cancel_no_ack", 32'({ref_ack, cpu_ack, gpu_ack}), 32'd0);
    tick(); #2;
    chk("cancel_no_rdv", 32'({ref_rdv, cpu_rdv, gpu_rdv}), 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
